// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one UART transmitter between NREQ byte streams.
// Optional stall timeout is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int          NREQ           = 2,
  parameter logic [23:0] GAP_CYCLES     = 24'd8000000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      byte_valid,
  input  logic [8*NREQ-1:0]    byte_data,
  input  logic [NREQ-1:0]      byte_last,
  output logic [NREQ-1:0]      byte_ready,
  output logic [NREQ-1:0]      grant,
  input  logic                 tx_busy,
  output logic                 tx_data_valid,
  output logic [7:0]           tx_data_in,
  output logic                 timeout
);

  // state     | meaning
  // IDLE      | no grant, searching requests round-robin
  // LOAD      | granted, waiting for a byte while the UART is free
  // STROBE    | one-cycle load strobe to the UART
  // WAIT_BUSY | waiting for the UART to start shifting
  // WAIT_IDLE | waiting for the frame to finish
  // GAP       | inter-message idle gap, grant still held
  typedef enum logic [2:0] {
    IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_IDLE, GAP
  } state_t;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_next;
  logic [PW-1:0]   rr_ptr, win;
  logic            found;
  logic [7:0]      sel_byte;
  logic            sel_last;
  logic            last_q;
  logic            xfer;
  logic            stall;
  logic            force_rel;
  logic            gap_done;
  logic [23:0]     cnt;
  logic [24:0]     cnt_inc;

  assign cnt_inc  = {1'b0, cnt} + 25'd1;
  assign gap_done = cnt_inc >= {1'b0, GAP_CYCLES};
  assign xfer     = |(byte_valid & byte_ready);

`ifdef UART_ARB_TIMEOUT_EN
  assign stall = ((state == LOAD) || (state == WAIT_BUSY) || (state == WAIT_IDLE)) &&
                 (cnt_inc >= {1'b0, TIMEOUT_CYCLES});
`else
  logic [23:0] tmo_unused;
  assign tmo_unused = TIMEOUT_CYCLES;
  assign stall      = 1'b0;
`endif

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  // rr_ptr always holds the current owner while a grant is active.
  always_comb begin
    sel_byte = 8'h00;
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_ptr == PW'(i)) begin
        sel_byte = byte_data[8*i +: 8];
        sel_last = byte_last[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= PW'(NREQ - 1);
      tx_data_in <= 8'h00;
      last_q     <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_next;
      cnt   <= ((state_next != state) || (state == IDLE)) ? 24'd0 : cnt + 24'd1;
      if ((state == IDLE) && found) begin
        grant  <= NREQ'(1) << win;
        rr_ptr <= win;
      end else if (((state == GAP) && gap_done) || force_rel) begin
        grant <= '0;
      end
      if ((state == LOAD) && xfer) begin
        tx_data_in <= sel_byte;
        last_q     <= sel_last;
      end
    end
  end

  always_comb begin
    state_next = state;
    force_rel  = 1'b0;
    case (state)
      IDLE:      if (found) state_next = LOAD;
      LOAD: begin
        if (xfer) state_next = STROBE;
        else if (stall) begin
          state_next = GAP;
          force_rel  = 1'b1;
        end
      end
      STROBE:    state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) state_next = WAIT_IDLE;
        else if (stall) begin
          state_next = GAP;
          force_rel  = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (!tx_busy) state_next = last_q ? GAP : LOAD;
        else if (stall) begin
          state_next = GAP;
          force_rel  = 1'b1;
        end
      end
      GAP:       if (gap_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_ready    = ((state == LOAD) && !tx_busy) ? grant : '0;
    tx_data_valid = (state == STROBE);
`ifdef UART_ARB_TIMEOUT_EN
    timeout       = force_rel;
`else
    timeout       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requester/UART models plus a round-robin message scoreboard.
// Timeout checks are compiled in only with UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;
  localparam int          NREQ = 2;
  localparam logic [23:0] GAP  = 24'd4;
  localparam logic [23:0] TMO  = 24'd16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, byte_valid, byte_last, byte_ready, grant;
  logic [8*NREQ-1:0] byte_data;
  logic              tx_busy, tx_data_valid, timeout;
  logic [7:0]        tx_data_in;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(byte_ready), .grant(grant), .tx_busy(tx_busy),
    .tx_data_valid(tx_data_valid), .tx_data_in(tx_data_in), .timeout(timeout)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0] rq [NREQ][$];     // {last, data} still to be offered by requester i
  int         mlen [NREQ][$];   // message lengths not yet handed to the model
  int         cur_len [NREQ];
  logic [7:0] exp_byte [$];
  int         exp_own [$];
  int         model_ptr;
  bit         midmsg [NREQ];
  bit         drop_mode [NREQ];
  bit         hold_valid [NREQ];
  bit         throttle;
  bit         busy_force;
  int         busy_len;
  int         busy_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input bit last);
    rq[i].push_back({last, d});
    cur_len[i]++;
    if (last) begin
      mlen[i].push_back(cur_len[i]);
      cur_len[i] = 0;
    end
  endtask

  task automatic add_msg(input int i, input int len);
    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom_range(0, 255)), b == len - 1);
  endtask

  // Expected byte order: whole messages, requesters visited in rotation after the last winner.
  task automatic plan();
    int pos [NREQ];
    int mi [NREQ];
    int w, k;
    logic [8:0] e;
    for (int i = 0; i < NREQ; i++) begin pos[i] = 0; mi[i] = 0; end
    while (1) begin
      w = -1;
      for (int s = 1; s <= NREQ; s++) begin
        k = (model_ptr + s) % NREQ;
        if (w < 0 && mi[k] < mlen[k].size()) w = k;
      end
      if (w < 0) break;
      for (int b = 0; b < mlen[w][mi[w]]; b++) begin
        e = rq[w][pos[w] + b];
        exp_byte.push_back(e[7:0]);
        exp_own.push_back(w);
      end
      pos[w] += mlen[w][mi[w]];
      mi[w]++;
      model_ptr = w;
    end
    for (int i = 0; i < NREQ; i++) mlen[i].delete();
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() != 0) begin
        e = rq[i][0];
        req[i]        = !(drop_mode[i] && midmsg[i]);
        byte_valid[i] = !hold_valid[i] && (!throttle || $urandom_range(0, 3) != 0);
        byte_data[8*i +: 8] = e[7:0];
        byte_last[i]  = e[8];
      end else begin
        req[i]        = 1'b0;
        byte_valid[i] = 1'b0;
        byte_last[i]  = 1'b0;
      end
    end
    if (tx_data_valid) busy_cnt = (busy_len != 0) ? busy_len : int'($urandom_range(2, 12));
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = busy_force || (busy_cnt != 0);
  endtask

  task automatic monitor();
    logic [8:0] e;
    logic [NREQ-1:0] x;
    if (!reset) return;
    x = byte_valid & byte_ready;
    if (byte_ready != 0) begin
      chk("ready_in_grant", 32'(byte_ready & ~grant), 0);
      chk("ready_when_busy", 32'(tx_busy), 0);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (x[i]) begin
        e = rq[i].pop_front();
        midmsg[i] = !e[8];
      end
    end
    if (tx_data_valid) begin
      if (exp_own.size() == 0) chk("strobe_unexpected", 1, 0);
      else begin
        chk("tx_byte", 32'(tx_data_in), 32'(exp_byte.pop_front()));
        chk("tx_owner", 32'(grant), 32'(1) << exp_own.pop_front());
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    drive();
    #4;
    monitor();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!(exp_own.size() == 0 && queues_empty() && grant == 0) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < budget), 1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) begin
      rq[i].delete();
      mlen[i].delete();
      cur_len[i] = 0;
      midmsg[i]  = 1'b0;
    end
    exp_byte.delete();
    exp_own.delete();
    model_ptr = NREQ - 1;
    busy_cnt  = 0;
  endtask

  initial begin
    int n, nz;
    reset = 1'b0;
    req = '0; byte_valid = '0; byte_data = '0; byte_last = '0; tx_busy = 1'b0;
    throttle = 1'b0; busy_force = 1'b0; busy_len = 10;
    for (int i = 0; i < NREQ; i++) begin drop_mode[i] = 1'b0; hold_valid[i] = 1'b0; end
    clear_model();
    repeat (3) tick();

    chk("rst_grant", 32'(grant), 0);
    chk("rst_tx_valid", 32'(tx_data_valid), 0);
    chk("rst_tx_data", 32'(tx_data_in), 0);
    chk("rst_ready", 32'(byte_ready), 0);
    chk("rst_timeout", 32'(timeout), 0);
    reset = 1'b1;
    tick();

    // Both request in the same cycle straight after reset.
    add_msg(0, 2); add_msg(0, 3); add_msg(1, 2);
    plan();
    drain("rr_both_drain", 2000);

    // Three-byte AT-style message, grant held through the gap.
    push_byte(0, 8'h41, 1'b0); push_byte(0, 8'h54, 1'b0); push_byte(0, 8'h0D, 1'b1);
    plan();
    n = 0;
    while (exp_own.size() != 0 && n < 500) begin tick(); n++; end
    chk("at_msg_sent", 32'(exp_own.size()), 0);
    n = 0;
    while (tx_busy && n < 100) begin tick(); n++; end
    chk("at_busy_fall", 32'(tx_busy), 0);
    chk("at_grant_held", 32'(grant), 1);
    // Grant still set while WAIT_IDLE sees the fall, then for GAP cycles.
    n = 0;
    while (grant != 0 && n < 50) begin n++; tick(); end
    chk("at_gap_len", n, 32'(GAP + 24'd1));
    drain("at_drain", 200);

    // Requester 1 drops req after its first byte; lock must hold.
    drop_mode[1] = 1'b1;
    add_msg(1, 3); add_msg(0, 1);
    plan();
    drain("lock_drain", 2000);
    drop_mode[1] = 1'b0;

    // UART busy already high when LOAD is entered.
    busy_force = 1'b1;
    add_msg(0, 1);
    plan();
    n = 0;
    while (grant == 0 && n < 50) begin tick(); n++; end
    chk("busy_grant", 32'(grant), 1);
    nz = 0;
    for (int c = 0; c < 20; c++) begin
      if (byte_ready != 0) nz++;
      tick();
    end
    chk("busy_no_ready", nz, 0);
    busy_force = 1'b0;
    tick();
    chk("busy_accept", 32'(byte_ready), 1);
    drain("busy_drain", 500);

    // Reset while the first byte is still on the line.
    add_msg(0, 2);
    plan();
    n = 0;
    while (exp_own.size() != 1 && n < 200) begin tick(); n++; end
    tick(); tick();
    chk("pre_rst_busy", 32'(tx_busy), 1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_valid", 32'(tx_data_valid), 0);
    chk("mid_rst_ready", 32'(byte_ready), 0);
    chk("mid_rst_data", 32'(tx_data_in), 0);
    clear_model();
    tick(); tick();
    reset = 1'b1;
    tick();
    add_msg(1, 2); add_msg(0, 1);
    plan();
    drain("post_rst_drain", 2000);

`ifdef UART_ARB_TIMEOUT_EN
    hold_valid[0] = 1'b1;
    push_byte(0, 8'h55, 1'b1);
    mlen[0].delete();
    n = 0;
    while (grant == 0 && n < 50) begin tick(); n++; end
    n = 1;
    while (!timeout && n < 100) begin tick(); n++; end
    chk("tmo_cycle", n, 16);
    rq[0].delete();
    hold_valid[0] = 1'b0;
    midmsg[0] = 1'b0;
    tick();
    chk("tmo_one_cycle", 32'(timeout), 0);
    repeat (int'(GAP) + 2) tick();
    chk("tmo_grant", 32'(grant), 0);
`endif

    // Random traffic: random lengths, byte gaps and UART frame times.
    throttle = 1'b1;
    busy_len = 0;
    for (int bt = 0; bt < 12; bt++) begin
      for (int i = 0; i < NREQ; i++) begin
        for (int m = 0; m < int'($urandom_range(0, 3)); m++) add_msg(i, int'($urandom_range(1, 4)));
      end
      plan();
      drain("rand_drain", 5000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
